// File: rtl/universal_shift_unit.sv
// Multi-mode shift/rotate register with a valid/ready command port.
// Loads and clears finish in one cycle; shifts and rotates step one bit per cycle.
module universal_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [CW-1:0]    cmd_amt_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             serial_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] out_o,
  output logic             serial_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_SRA   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_r;
  logic             serial_r;
  logic             done_r;
  logic [WIDTH:0]   step_s;

  // One 1-bit step; the MSB of the result is the bit shifted out.
  function automatic logic [WIDTH:0] step_f(input logic [2:0] op,
                                            input logic [WIDTH-1:0] d,
                                            input logic sin);
    logic [WIDTH:0] r;
    case (op)
      OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], sin};
      OP_SHR:  r = {d[0], sin, d[WIDTH-1:1]};
      OP_SRA:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      default: r = {serial_r, d};
    endcase
    return r;
  endfunction

  // Next-step datapath value for the latched operation.
  always_comb begin
    step_s = step_f(op_r, out_r, serial_i);
  end

  // Command acceptance, stepping, abort and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= OP_NOP;
      cnt_r    <= '0;
      out_r    <= '0;
      serial_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (cmd_valid_i) begin
            case (cmd_op_i)
              OP_NOP:   done_r <= 1'b1;
              OP_LOAD: begin
                out_r  <= word_i;
                done_r <= 1'b1;
              end
              OP_CLEAR: begin
                out_r  <= '0;
                done_r <= 1'b1;
              end
              default: begin
                // A zero count completes immediately without touching the data.
                if (cmd_amt_i == '0) begin
                  done_r <= 1'b1;
                end else begin
                  state_r <= RUN;
                  op_r    <= cmd_op_i;
                  cnt_r   <= cmd_amt_i;
                end
              end
            endcase
          end
        end
        RUN: begin
          if (abort_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            done_r  <= 1'b0;
          end else begin
            out_r    <= step_s[WIDTH-1:0];
            serial_r <= step_s[WIDTH];
            cnt_r    <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              state_r <= IDLE;
              done_r  <= 1'b1;
            end else begin
              done_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_r == IDLE);
  assign busy_o      = (state_r == RUN);
  assign out_o       = out_r;
  assign serial_o    = serial_r;
  assign done_o      = done_r;

endmodule

// File: tb/tb_universal_shift_unit.sv
// Directed self-checking bench for universal_shift_unit (WIDTH=8).
module tb_universal_shift_unit;

  localparam int WIDTH = 8;
  localparam int CW = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op_i;
  logic [CW-1:0]    cmd_amt_i;
  logic [WIDTH-1:0] word_i;
  logic             serial_i;
  logic             abort_i;
  logic [WIDTH-1:0] out_o;
  logic             serial_o;
  logic             busy_o;
  logic             done_o;

  int check_count = 0;
  int error_count = 0;

  universal_shift_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_amt_i(cmd_amt_i), .word_i(word_i),
    .serial_i(serial_i), .abort_i(abort_i),
    .out_o(out_o), .serial_o(serial_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [CW-1:0] amt,
                      input logic [WIDTH-1:0] w, input logic sin);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_amt_i   = amt;
    word_i      = w;
    serial_i    = sin;
  endtask

  task automatic load_idle(input logic [WIDTH-1:0] w);
    send(3'b001, 4'd0, w, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] o, input logic so);
    check_value({tag, "_out"}, 32'(out_o), 32'(o));
    check_value({tag, "_so"}, 32'(serial_o), 32'(so));
    check_value({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_value({tag, "_done"}, 32'(done_o), 32'd0);
    check_value({tag, "_rdy"}, 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_op_i = 3'b000; cmd_amt_i = 4'd0;
    word_i = 8'h00; serial_i = 1'b0; abort_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset", 8'h00, 1'b0);

    // LOAD then CLEAR back-to-back
    send(3'b001, 4'd0, 8'hA5, 1'b0);
    tick();
    check_value("load_out", 32'(out_o), 32'h0000_00A5);
    check_value("load_done", 32'(done_o), 32'd1);
    check_value("load_rdy", 32'(cmd_ready_o), 32'd1);
    send(3'b111, 4'd0, 8'h00, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    check_value("clear_out", 32'(out_o), 32'd0);
    check_value("clear_done", 32'(done_o), 32'd1);
    tick();
    check_value("clear_done_drop", 32'(done_o), 32'd0);

    // SHL by 3 with serial_i=1 from 0xA5
    load_idle(8'hA5);
    send(3'b010, 4'd3, 8'h00, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    check_value("shl_e0_out", 32'(out_o), 32'h0000_00A5);
    check_value("shl_e0_busy", 32'(busy_o), 32'd1);
    check_value("shl_e0_rdy", 32'(cmd_ready_o), 32'd0);
    tick();
    check_value("shl_s1_out", 32'(out_o), 32'h0000_004B);
    check_value("shl_s1_so", 32'(serial_o), 32'd1);
    check_value("shl_s1_done", 32'(done_o), 32'd0);
    tick();
    check_value("shl_s2_out", 32'(out_o), 32'h0000_0097);
    check_value("shl_s2_so", 32'(serial_o), 32'd0);
    check_value("shl_s2_busy", 32'(busy_o), 32'd1);
    tick();
    check_value("shl_s3_out", 32'(out_o), 32'h0000_002F);
    check_value("shl_s3_so", 32'(serial_o), 32'd1);
    check_value("shl_s3_busy", 32'(busy_o), 32'd0);
    check_value("shl_s3_done", 32'(done_o), 32'd1);
    check_value("shl_s3_rdy", 32'(cmd_ready_o), 32'd1);
    tick();
    check_value("shl_done_drop", 32'(done_o), 32'd0);

    // SRA by 2 from 0x90
    load_idle(8'h90);
    send(3'b100, 4'd2, 8'h00, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    tick(); tick();
    check_value("sra_out", 32'(out_o), 32'h0000_00E4);
    check_value("sra_so", 32'(serial_o), 32'd0);
    check_value("sra_done", 32'(done_o), 32'd1);

    // ROR by 9 from 0x81 (count above WIDTH wraps naturally)
    load_idle(8'h81);
    send(3'b110, 4'd9, 8'h00, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_value("ror_s8_done", 32'(done_o), 32'd0);
    check_value("ror_s8_busy", 32'(busy_o), 32'd1);
    tick();
    check_value("ror_out", 32'(out_o), 32'h0000_00C0);
    check_value("ror_so", 32'(serial_o), 32'd1);
    check_value("ror_done", 32'(done_o), 32'd1);

    // LOAD keeps serial_o; ROL by 0 is a single-cycle no-op
    load_idle(8'h81);
    check_value("load_keeps_so", 32'(serial_o), 32'd1);
    send(3'b101, 4'd0, 8'h00, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    check_value("rol0_out", 32'(out_o), 32'h0000_0081);
    check_value("rol0_done", 32'(done_o), 32'd1);
    check_value("rol0_busy", 32'(busy_o), 32'd0);
    check_value("rol0_so", 32'(serial_o), 32'd1);

    // SHR by 5 from 0xFF, aborted on third RUN edge; LOAD held valid meanwhile
    load_idle(8'hFF);
    send(3'b011, 4'd5, 8'h00, 1'b0);
    tick();
    send(3'b001, 4'd0, 8'h55, 1'b0);
    tick();
    check_value("shr_s1_out", 32'(out_o), 32'h0000_007F);
    check_value("shr_s1_so", 32'(serial_o), 32'd1);
    tick();
    check_value("shr_s2_out", 32'(out_o), 32'h0000_003F);
    cmd_valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_idle_outputs("abort", 8'h3F, 1'b1);
    tick();
    check_value("abort_after_done", 32'(done_o), 32'd0);
    check_value("abort_after_out", 32'(out_o), 32'h0000_003F);

    // Back-to-back LOAD then SHL by 1 with valid held
    send(3'b001, 4'd0, 8'h01, 1'b0);
    tick();
    check_value("b2b_load_out", 32'(out_o), 32'h0000_0001);
    check_value("b2b_load_done", 32'(done_o), 32'd1);
    send(3'b010, 4'd1, 8'h00, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    check_value("b2b_shl_busy", 32'(busy_o), 32'd1);
    check_value("b2b_shl_nodone", 32'(done_o), 32'd0);
    tick();
    check_value("b2b_shl_out", 32'(out_o), 32'h0000_0002);
    check_value("b2b_shl_done", 32'(done_o), 32'd1);
    check_value("b2b_shl_so", 32'(serial_o), 32'd0);

    // Async reset mid-RUN
    load_idle(8'hF0);
    send(3'b101, 4'd5, 8'h00, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check_value("rol_s1_out", 32'(out_o), 32'h0000_00E1);
    check_value("rol_s1_so", 32'(serial_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrun_rst", 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("post_rst", 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
